// File: rtl/axilite_rd_seq.sv
// rtl/axilite_rd_seq.sv - AXI4-Lite read request sequencer
// Splits an N-word read command into credit-limited single-word requests and indexes the returned words.
module axilite_rd_seq #(
  parameter int AXI_ADDR_WIDTH     = 32,
  parameter int USER_RD_DATA_WIDTH = 32,
  parameter int LEN_WIDTH          = 8,
  parameter int MAX_OUTSTANDING    = 8,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [AXI_ADDR_WIDTH-1:0]     start_addr,
  input  logic [LEN_WIDTH-1:0]          rd_len,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic                          err_spurious,
  output logic                          user_rd_en,
  output logic [AXI_ADDR_WIDTH-1:0]     user_rd_addr,
  input  logic                          user_rd_ready,
  input  logic [USER_RD_DATA_WIDTH-1:0] user_rd_data,
  input  logic                          user_rd_valid,
  output logic [USER_RD_DATA_WIDTH-1:0] out_data,
  output logic                          out_valid,
  output logic [LEN_WIDTH-1:0]          out_index,
  output logic                          out_last
);
  localparam int CW = LEN_WIDTH + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] STEP = AXI_ADDR_WIDTH'(USER_RD_DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [AXI_ADDR_WIDTH-1:0]     r_next_addr, r_rd_addr;
  logic [CW-1:0]                 r_len, r_issued, r_received;
  logic [OW-1:0]                 r_outstanding;
  logic [TW-1:0]                 r_timer;
  logic                          r_rd_en, r_out_valid, r_out_last;
  logic                          r_err_timeout, r_err_spurious;
  logic [USER_RD_DATA_WIDTH-1:0] r_out_data;
  logic [LEN_WIDTH-1:0]          r_out_index;
  logic                          w_active, w_start, w_issue, w_accept, w_idle_tick, w_timeout;

  assign w_active    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_start     = (r_state == S_IDLE) && start;
  assign w_issue     = (r_state == S_ISSUE) && user_rd_ready && (r_issued < r_len) &&
                       (r_outstanding < OW'(MAX_OUTSTANDING));
  assign w_accept    = w_active && user_rd_valid && (r_outstanding != '0);
  // Idle means waiting on the read channel with nothing issued or returned this cycle.
  assign w_idle_tick = w_active && (r_outstanding != '0) && !w_issue && !w_accept;
  assign w_timeout   = w_idle_tick && (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (rd_len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_timeout) w_state_nxt = S_DONE;
               else if (r_issued == r_len) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_timeout || (r_received == r_len)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_next_addr    <= '0;
      r_rd_addr      <= '0;
      r_len          <= '0;
      r_issued       <= '0;
      r_received     <= '0;
      r_outstanding  <= '0;
      r_timer        <= '0;
      r_rd_en        <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_out_data     <= '0;
      r_out_index    <= '0;
      r_err_timeout  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_rd_en     <= w_issue;
      r_out_valid <= w_accept;
      r_out_last  <= w_accept && (r_received == r_len - CW'(1));
      if (w_accept) begin
        r_out_data  <= user_rd_data;
        r_out_index <= r_received[LEN_WIDTH-1:0];
      end
      if (w_start) begin
        r_next_addr    <= start_addr;
        r_len          <= {1'b0, rd_len};
        r_issued       <= '0;
        r_received     <= '0;
        r_outstanding  <= '0;
        r_timer        <= '0;
        r_err_timeout  <= 1'b0;
        r_err_spurious <= 1'b0;
      end else begin
        if (w_issue) begin
          r_rd_addr   <= r_next_addr;
          r_next_addr <= r_next_addr + STEP;
          r_issued    <= r_issued + CW'(1);
        end
        if (w_accept) r_received <= r_received + CW'(1);
        if (w_timeout) begin
          r_outstanding <= '0;
          r_err_timeout <= 1'b1;
        end else if (w_issue && !w_accept) begin
          r_outstanding <= r_outstanding + OW'(1);
        end else if (!w_issue && w_accept) begin
          r_outstanding <= r_outstanding - OW'(1);
        end
        if (w_issue || w_accept || w_timeout) r_timer <= '0;
        else if (w_idle_tick)                 r_timer <= r_timer + TW'(1);
      end
      if (user_rd_valid && !w_accept) r_err_spurious <= 1'b1;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign err_timeout  = r_err_timeout;
  assign err_spurious = r_err_spurious;
  assign user_rd_en   = r_rd_en;
  assign user_rd_addr = r_rd_addr;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_index    = r_out_index;
  assign out_last     = r_out_last;
endmodule

// File: tb/tb_axilite_rd_seq.sv
// tb/tb_axilite_rd_seq.sv - self-checking bench for axilite_rd_seq
// Read-channel model with latency/hold/ready-pattern control, address and return-word scoreboards.
module tb_axilite_rd_seq;
  localparam int AW = 32, DW = 32, LW = 8, MO = 8, TO = 1024;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] rd_len = '0;
  logic          busy, done, err_timeout, err_spurious, user_rd_en, out_valid, out_last;
  logic [AW-1:0] user_rd_addr;
  logic          user_rd_ready = 1'b1, user_rd_valid = 1'b0;
  logic [DW-1:0] user_rd_data = '0, out_data;
  logic [LW-1:0] out_index;

  always #5 clk = ~clk;

  axilite_rd_seq #(.AXI_ADDR_WIDTH(AW), .USER_RD_DATA_WIDTH(DW), .LEN_WIDTH(LW),
                   .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr), .rd_len(rd_len),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_spurious(err_spurious),
    .user_rd_en(user_rd_en), .user_rd_addr(user_rd_addr), .user_rd_ready(user_rd_ready),
    .user_rd_data(user_rd_data), .user_rd_valid(user_rd_valid),
    .out_data(out_data), .out_valid(out_valid), .out_index(out_index), .out_last(out_last));

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] data; logic [7:0] idx; logic last; } exp_out_t;
  typedef struct { logic [31:0] addr; int len; int lat; int hold; bit pat; int exp_stall; } vec_t;

  logic [31:0] exp_addr_q[$];
  exp_out_t    exp_out_q[$];
  pend_t       pend_q[$];
  logic [31:0] late_q[$];

  int    tests = 0, fails = 0, cyc = 0;
  int    lat = 3, hold_until = 0, answer_limit = 1 << 30, cur_len = 0;
  int    req_cnt = 0, resp_cnt = 0, done_cnt = 0, max_outst = 0, first_out_cyc = -1, to_cyc = -1;
  bit    pat_en = 1'b0, inject_late = 1'b0, prev_ready = 1'b1, prev_to = 1'b0;
  logic [4:0] rpat = 5'b01001;
  string cur_tag = "reset";
  vec_t  vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  // Read-channel model and output monitor, all evaluated away from the rising edge.
  initial forever begin
    exp_out_t e;
    pend_t    p;
    logic [31:0] a;
    @(negedge clk);
    if (done) done_cnt++;
    if (err_timeout && !prev_to) to_cyc = cyc;
    prev_to = err_timeout;
    if (out_valid) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (exp_out_q.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
      else begin
        e = exp_out_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_index", 64'(out_index), 64'(e.idx));
        check("out_last", 64'(out_last), 64'(e.last));
      end
    end
    if (user_rd_en) begin
      check("en_after_ready_low", 64'(user_rd_en && !prev_ready), 64'd0);
      if (exp_addr_q.size() == 0) check("unexpected_req", 64'(user_rd_en), 64'd0);
      else check("req_addr", 64'(user_rd_addr), 64'(exp_addr_q.pop_front()));
      req_cnt++;
      if (req_cnt <= answer_limit) pend_q.push_back('{addr: user_rd_addr, due: cyc + lat});
      else late_q.push_back(user_rd_addr);
    end
    if (req_cnt - resp_cnt > max_outst) max_outst = req_cnt - resp_cnt;
    user_rd_valid = 1'b0;
    if (inject_late && late_q.size() > 0) begin
      a = late_q.pop_front();
      user_rd_valid = 1'b1;
      user_rd_data  = data_of(a);
      inject_late   = 1'b0;
    end else if (cyc >= hold_until && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      user_rd_valid = 1'b1;
      user_rd_data  = data_of(p.addr);
      e.data = data_of(p.addr);
      e.idx  = 8'(resp_cnt);
      e.last = (resp_cnt == cur_len - 1);
      exp_out_q.push_back(e);
      resp_cnt++;
    end
    user_rd_ready = pat_en ? rpat[cyc % 5] : 1'b1;
    prev_ready = user_rd_ready;
  end

  task automatic start_cmd(input logic [31:0] a, input int n, input int l, input int h,
                           input bit p, input int lim);
    @(negedge clk); #1;
    lat = l; pat_en = p; answer_limit = lim; cur_len = n; hold_until = cyc + h;
    req_cnt = 0; resp_cnt = 0; done_cnt = 0; max_outst = 0; first_out_cyc = -1; to_cyc = -1;
    for (int i = 0; i < n; i++) exp_addr_q.push_back(a + 32'(i) * 32'd4);
    start = 1'b1; start_addr = a; rd_len = 8'(n);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_within_budget", 64'(done_cnt != 0), 64'd1);
    repeat (3) begin @(negedge clk); #1; end
  endtask

  task automatic end_checks(input int exp_req, input bit exp_to, input bit exp_sp);
    check("req_count", 64'(req_cnt), 64'(exp_req));
    check("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
    check("out_q_empty", 64'(exp_out_q.size()), 64'd0);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("err_timeout", 64'(err_timeout), 64'(exp_to));
    check("err_spurious", 64'(err_spurious), 64'(exp_sp));
    check("busy_after", 64'(busy), 64'd0);
    check("outstanding_le_limit", 64'(max_outst <= MO), 64'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{addr: 32'h0000_1000, len: 4,   lat: 3,  hold: 0,  pat: 1'b0, exp_stall: 0};
    vecs[1] = '{addr: 32'h0000_2000, len: 20,  lat: 3,  hold: 50, pat: 1'b0, exp_stall: MO};
    vecs[2] = '{addr: 32'h0000_3000, len: 6,   lat: 3,  hold: 0,  pat: 1'b1, exp_stall: 0};
    vecs[3] = '{addr: 32'hFFFF_FFF8, len: 3,   lat: 3,  hold: 0,  pat: 1'b0, exp_stall: 0};
    vecs[4] = '{addr: 32'h0000_0100, len: 255, lat: 1,  hold: 0,  pat: 1'b0, exp_stall: 0};
    vecs[5] = '{addr: 32'h0000_4000, len: 9,   lat: 12, hold: 0,  pat: 1'b0, exp_stall: 0};

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(user_rd_en), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_errs", 64'({err_timeout, err_spurious}), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      start_cmd(vecs[i].addr, vecs[i].len, vecs[i].lat, vecs[i].hold, vecs[i].pat, 1 << 30);
      if (vecs[i].hold > 0) begin
        repeat (vecs[i].hold - 10) begin @(negedge clk); #1; end
        check("stall_reqs", 64'(req_cnt), 64'(vecs[i].exp_stall));
        check("stall_outstanding", 64'(max_outst), 64'(vecs[i].exp_stall));
      end
      wait_done(3000);
      end_checks(vecs[i].len, 1'b0, 1'b0);
    end

    cur_tag = "timeout";
    start_cmd(32'h0000_6000, 2, 3, 0, 1'b0, 1);
    wait_done(1500);
    check("timeout_delay", 64'(to_cyc - first_out_cyc), 64'(TO));
    end_checks(2, 1'b1, 1'b0);
    inject_late = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    check("late_word_spurious", 64'(err_spurious), 64'd1);

    cur_tag = "len0";
    start_cmd(32'h0000_7000, 0, 3, 0, 1'b0, 1 << 30);
    check("done_next_cycle", 64'(done_cnt), 64'd1);
    wait_done(5);
    end_checks(0, 1'b0, 1'b0);

    cur_tag = "idle_spurious";
    late_q.push_back(32'hDEAD_BEE0);
    inject_late = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    check("err_spurious_set", 64'(err_spurious), 64'd1);

    cur_tag = "start_busy";
    start_cmd(32'h0000_5000, 4, 3, 0, 1'b0, 1 << 30);
    check("start_clears_spurious", 64'(err_spurious), 64'd0);
    start = 1'b1; start_addr = 32'h0000_9000; rd_len = 8'd2;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(200);
    end_checks(4, 1'b0, 1'b0);
    repeat (10) begin @(negedge clk); #1; end
    check("no_second_cmd", 64'(done_cnt), 64'd1);

    cur_tag = "reset_drain";
    start_cmd(32'h0000_8000, 4, 20, 0, 1'b0, 1 << 30);
    repeat (8) begin @(negedge clk); #1; end
    check("pre_reset_busy", 64'(busy), 64'd1);
    check("pre_reset_reqs", 64'(req_cnt), 64'd4);
    reset_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(user_rd_en), 64'd0);
    check("rst_rd_addr", 64'(user_rd_addr), 64'd0);
    check("rst_out", 64'({out_valid, out_last, out_index, out_data}), 64'd0);
    check("rst_errs", 64'({err_timeout, err_spurious}), 64'd0);
    pend_q.delete();
    exp_addr_q.delete();
    exp_out_q.delete();
    repeat (2) begin @(negedge clk); #1; end
    reset_n = 1'b1;
    repeat (30) begin @(negedge clk); #1; end
    check("post_reset_idle", 64'({busy, out_valid, user_rd_en}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
